sync_binary_counter_11: RTL and testbench
=========================================

# sync_binary_counter_11

Four-bit synchronous binary up-counter with asynchronous clear, synchronous parallel load, count enable and ripple-carry output, functionally equivalent to a 74x161. It serves as the reusable counting stage in the lab datapath. Multiple instances cascade into wider counters by feeding each stage's `co` into the next stage's `en`, with all stages sharing `clk` and `mr`.

## Interface
- Parameters: `WIDTH`, default 4, counter width in bits. All behaviour below is written for `WIDTH` = 4 and generalises to any `WIDTH` ≥ 1.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  input  1  clock; all synchronous state changes occur on the rising edge.
- `mr`  input  1  master reset, asynchronous, active-low; clears the counter.
- `load`  input  1  parallel load, synchronous, active-low.
- `en`  input  1  count enable, active-high.
- `d`  input  WIDTH  parallel load data.
- `q`  output  WIDTH  counter state, registered.
- `co`  output  1  ripple carry out, combinational.

## Operation
Priority of control inputs, highest first:
- `mr` = 0: `q` ← 0 immediately, independent of `clk`. The counter stays at 0 while `mr` is held low. All other inputs are ignored.
- `mr` = 1, `load` = 0: on the rising edge of `clk`, `q` ← `d`. The value of `en` has no effect.
- `mr` = 1, `load` = 1, `en` = 1: on the rising edge, `q` ← (`q` + 1) mod 2^WIDTH. After 4'b1111 the counter wraps to 4'b0000.
- `mr` = 1, `load` = 1, `en` = 0: `q` holds its value.

Carry output:
- `co` = `en` AND (`q` == 2^WIDTH − 1). For `WIDTH` = 4, `co` = 1 only when `q` = 15 and `en` = 1.
- `co` is purely combinational from `q` and `en`. It is not registered and is not gated by `load` or `mr`.
- During reset, `q` = 0, so `co` = 0.

Other rules:
- `d` is sampled only at a rising edge while `load` = 0. Changes to `d` at any other time have no effect on `q`.
- There is no down-count, no terminal-count stop, and no saturation.
- Reset values: `q` = 0 and `co` = 0.

## Timing
- Load latency: 1 cycle. `q` equals `d` right after the first rising edge at which `load` = 0 and `mr` = 1.
- Count latency: 1 cycle per increment.
- `mr` assertion acts without waiting for a clock edge.
- Reset release: when `mr` rises to 1, the first rising edge at or after the release performs a normal operation (load, count or hold). This is the same as a synchronous de-assert.
- Load during count: if `load` = 0 and `en` = 1 at the same edge, the load wins.
- Wrap case: if `q` = 15 and `en` = 1 at an edge, `q` becomes 0 after the edge and `co` falls in the same cycle.
- Cascading: in a chain of stages, stage N+1 increments exactly at the edge where stage N wraps from 15 to 0.
- Reset mid-count: the counter goes to 0 immediately. Any pending load or increment for that cycle is lost.

## Test plan
- Reset: set `mr` = 0 with arbitrary other inputs, and toggle `clk` for several edges. Required: `q` = 0 and `co` = 0 at all times, including between edges.
- Load: from `mr` = 1, apply `load` = 0, `d` = 4'b0011, `en` = 0, then one rising edge. Required: `q` = 3. Then set `load` = 1 and `en` = 0 and apply 3 edges. Required: `q` stays 3.
- Count and wrap: load 4'b1101, then set `load` = 1, `en` = 1 and apply 4 edges. Required sequence for `q`: 14, 15, 0, 1. `co` = 1 only while `q` = 15.
- Carry gating: with `q` = 15, toggle `en` between 1 and 0 without any clock edge. Required: `co` follows `en`, and `q` stays 15.
- Priority: with `q` = 7, set `en` = 1, `load` = 0, `d` = 4'b1010 and apply one edge. Required: `q` = 10, not 8. Then, mid-cycle with `q` = 10, set `mr` = 0. Required: `q` = 0 before the next edge.
- Cascade: connect two instances with the low stage's `co` driving the high stage's `en`. Starting from 0 with `en` = 1, apply 20 edges. Required: high stage = 1 and low stage = 4, i.e. an 8-bit total of 20.

Source files
------------

// File: rtl/sync_binary_counter_11.sv
// Four-bit (parameterisable) synchronous up-counter in the 74x161 style: async clear,
// synchronous active-low parallel load, count enable, and combinational ripple carry.
module sync_binary_counter_11 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             mr,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             co
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Load beats count; with neither, the counter holds.
    always_comb begin
        // NOTE: assigning the default first keeps every path driven, so no latch is inferred.
        q_d = q_q;
        if (!load) begin
            q_d = d;
        end else if (en) begin
            q_d = q_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge mr) begin
        // NOTE: non-blocking assignments make all flops update together at the edge.
        if (!mr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    // Ungated by load or mr so the next stage's enable sees it in the same cycle.
    assign co = en & (&q_q);

endmodule

// File: tb/tb_sync_binary_counter_11.sv
// Directed bench for sync_binary_counter_11: reset, load/hold, count and wrap,
// carry gating, load-over-count priority, async clear, and a two-stage cascade.
module tb_sync_binary_counter_11;

    logic       clk;
    logic       mr;
    logic       load;
    logic       en;
    logic [3:0] d;
    logic [3:0] q;
    logic       co;

    logic       c_mr;
    logic [3:0] lo_q;
    logic [3:0] hi_q;
    logic       lo_co;
    logic       hi_co;

    int n_checks = 0;
    int n_fails  = 0;

    sync_binary_counter_11 #(.WIDTH(4)) dut (
        .clk  (clk),
        .mr   (mr),
        .load (load),
        .en   (en),
        .d    (d),
        .q    (q),
        .co   (co)
    );

    sync_binary_counter_11 #(.WIDTH(4)) u_lo (
        .clk  (clk),
        .mr   (c_mr),
        .load (1'b1),
        .en   (1'b1),
        .d    (4'h0),
        .q    (lo_q),
        .co   (lo_co)
    );

    sync_binary_counter_11 #(.WIDTH(4)) u_hi (
        .clk  (clk),
        .mr   (c_mr),
        .load (1'b1),
        .en   (lo_co),
        .d    (4'h0),
        .q    (hi_q),
        .co   (hi_co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mr   = 1'b0;
        load = 1'b0;
        en   = 1'b1;
        d    = 4'hA;
        c_mr = 1'b0;
        #2;
        check("reset_q_start", 32'(q), 0);
        check("reset_co_start", 32'(co), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_q_edge", 32'(q), 0);
            check("reset_co_edge", 32'(co), 0);
            #3;
            check("reset_q_mid", 32'(q), 0);
        end

        // Release reset after an edge; load 3 with en low.
        tick();
        mr   = 1'b1;
        load = 1'b0;
        d    = 4'd3;
        en   = 1'b0;
        tick();
        check("load_3", 32'(q), 3);

        load = 1'b1;
        en   = 1'b0;
        d    = 4'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_3", 32'(q), 3);
        end

        // Count and wrap from 13.
        load = 1'b0;
        d    = 4'd13;
        tick();
        check("load_13", 32'(q), 13);
        load = 1'b1;
        en   = 1'b1;
        tick();
        check("count_14", 32'(q), 14);
        check("co_at_14", 32'(co), 0);
        tick();
        check("count_15", 32'(q), 15);
        check("co_at_15", 32'(co), 1);
        tick();
        check("wrap_0", 32'(q), 0);
        check("co_after_wrap", 32'(co), 0);
        tick();
        check("count_1", 32'(q), 1);
        check("co_at_1", 32'(co), 0);

        // Carry follows en between edges.
        load = 1'b0;
        d    = 4'd15;
        en   = 1'b0;
        tick();
        check("load_15", 32'(q), 15);
        check("co_en0", 32'(co), 0);
        load = 1'b1;
        en   = 1'b1;
        #1;
        check("co_en1", 32'(co), 1);
        en = 1'b0;
        #1;
        check("co_en0_again", 32'(co), 0);
        check("gating_q_15", 32'(q), 15);

        // Load wins over count.
        load = 1'b0;
        d    = 4'd7;
        tick();
        check("load_7", 32'(q), 7);
        en   = 1'b1;
        load = 1'b0;
        d    = 4'd10;
        tick();
        check("load_beats_count", 32'(q), 10);

        // Async clear mid-cycle.
        #2;
        mr = 1'b0;
        #1;
        check("async_clear_q", 32'(q), 0);
        check("async_clear_co", 32'(co), 0);

        // First edge after release performs a normal count.
        tick();
        mr   = 1'b1;
        load = 1'b1;
        en   = 1'b1;
        tick();
        check("release_count", 32'(q), 1);

        // Two-stage cascade: 20 edges from zero.
        c_mr = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("cascade_total", 32'({hi_q, lo_q}), 32'(i));
        end
        check("cascade_hi", 32'(hi_q), 1);
        check("cascade_lo", 32'(lo_q), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
